// File: rtl/dual_grant_sequencer.sv
// Two-step priority grant sequencer: accepts a (first, second) code pair and
// issues up to two one-hot grants in turn, each ended by done or a hold timeout.
module dual_grant_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic [3:0]  first_code,
  input  logic [3:0]  second_code,
  input  logic        done,
  output logic [11:0] grant,
  output logic [3:0]  grant_code,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  state_t      state_reg, state_next;
  logic [11:0] grant_reg, grant_next;
  logic [3:0]  code_reg, code_next;
  logic [3:0]  second_reg, second_next;
  logic        busy_reg, busy_next;
  logic        timeout_reg, timeout_next;
  logic [15:0] hold_reg, hold_next;

  logic [11:0] first_hot, second_hot, pend_hot;
  logic        first_ok, second_ok, hold_end;

  // Code-to-one-hot decoders; codes outside 1..12 decode to all-zero ("none").
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_decode
      assign first_hot[gi]  = (first_code  == 4'(gi + 1));
      assign second_hot[gi] = (second_code == 4'(gi + 1));
      assign pend_hot[gi]   = (second_reg  == 4'(gi + 1));
    end
  endgenerate

  assign first_ok   = |first_hot;
  assign second_ok  = (|second_hot) && (second_code != first_code);
  assign hold_end   = done || (hold_reg == TIMEOUT_CYCLES - 16'd1);
  assign code_ready = (state_reg == IDLE);

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    code_next    = code_reg;
    second_next  = second_reg;
    busy_next    = busy_reg;
    timeout_next = timeout_reg;
    hold_next    = hold_reg;
    case (state_reg)
      IDLE: begin
        if (code_valid && first_ok) begin
          state_next  = GRANT1;
          grant_next  = first_hot;
          code_next   = first_code;
          busy_next   = 1'b1;
          hold_next   = 16'd0;
          second_next = second_ok ? second_code : 4'd0;
        end
      end
      GRANT1, GRANT2: begin
        hold_next = hold_reg + 16'd1;
        if (hold_end) begin
          if (!done) timeout_next = 1'b1;
          hold_next = 16'd0;
          // A nonzero pending code means the second grant was not skipped.
          if (state_reg == GRANT1 && second_reg != 4'd0) begin
            state_next  = GRANT2;
            grant_next  = pend_hot;
            code_next   = second_reg;
            second_next = 4'd0;
          end else begin
            state_next  = IDLE;
            grant_next  = 12'd0;
            code_next   = 4'd0;
            busy_next   = 1'b0;
            second_next = 4'd0;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        grant_next  = 12'd0;
        code_next   = 4'd0;
        busy_next   = 1'b0;
        second_next = 4'd0;
        hold_next   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= 12'd0;
      code_reg    <= 4'd0;
      second_reg  <= 4'd0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      hold_reg    <= 16'd0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      code_reg    <= code_next;
      second_reg  <= second_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
      hold_reg    <= hold_next;
    end
  end

  assign grant        = grant_reg;
  assign grant_code   = code_reg;
  assign busy         = busy_reg;
  assign timeout_flag = timeout_reg;

endmodule

// File: tb/tb_dual_grant_sequencer.sv
// Bench for dual_grant_sequencer: directed scenarios plus random code pairs,
// predicted per transaction as a list of (code, duration) grants.
module tb_dual_grant_sequencer;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  first_code;
  logic [3:0]  second_code;
  logic        done;
  logic [11:0] grant;
  logic [3:0]  grant_code;
  logic        busy;
  logic        timeout_flag;

  int total = 0;
  int bad   = 0;
  logic exp_to = 1'b0;

  dual_grant_sequencer #(.TIMEOUT_CYCLES(16'(T))) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_ready(code_ready),
    .first_code(first_code), .second_code(second_code), .done(done),
    .grant(grant), .grant_code(grant_code), .busy(busy),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".code"}, 32'(grant_code), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(code_ready), 32'd1);
    chk({tag, ".tflag"}, 32'(timeout_flag), 32'(exp_to));
  endtask

  function automatic bit code_ok(input int c);
    return (c >= 1 && c <= 12);
  endfunction

  // Present one pair at a negedge, then walk the predicted grant list.
  // d1/d2: cycle of the grant on which done is driven high (> T means never).
  task automatic run_pair(input int f, input int s, input int d1, input int d2,
                          input bit noisy, input string tag);
    int codes[$];
    int durs[$];
    code_valid  = 1'b1;
    first_code  = 4'(f);
    second_code = 4'(s);
    done        = 1'b0;
    chk({tag, ".ready_pre"}, 32'(code_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    if (code_ok(f)) begin
      codes.push_back(f); durs.push_back(d1);
      if (code_ok(s) && s != f) begin
        codes.push_back(s); durs.push_back(d2);
      end
    end
    foreach (codes[i]) begin
      int len;
      len = (durs[i] > T) ? T : durs[i];
      for (int k = 1; k <= len; k++) begin
        if (noisy) begin
          code_valid  = 1'($urandom);
          first_code  = 4'($urandom);
          second_code = 4'($urandom);
        end
        done = (k == durs[i]);
        chk({tag, ".grant"}, 32'(grant), 32'(12'd1 << (codes[i] - 1)));
        chk({tag, ".code"}, 32'(grant_code), 32'(codes[i]));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".ready"}, 32'(code_ready), 32'd0);
        chk({tag, ".tflag"}, 32'(timeout_flag), 32'(exp_to));
        @(posedge clk);
        @(negedge clk);
      end
      if (durs[i] > T) exp_to = 1'b1;
    end
    code_valid = 1'b0;
    done       = 1'b0;
    chk_idle({tag, ".end"});
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; first_code = '0; second_code = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    run_pair(12, 5, 3, 2, 1'b0, "s12_5");
    run_pair(3, 3, 2, 1, 1'b0, "s3_3");
    run_pair(0, 7, 1, 1, 1'b0, "s0_7");
    run_pair(14, 2, 1, 1, 1'b0, "s14_2");
    run_pair(1, 0, T + 3, 1, 1'b0, "tmo1");
    run_pair(6, 9, 1, T + 1, 1'b0, "tmo2");
    run_pair(4, 11, 2, 1, 1'b1, "noisy");

    // done pulsed while idle must leave the block idle
    done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done = 1'b0;
    chk_idle("idle_done");

    // reset on 2nd cycle of GRANT1 discards the pending second grant
    code_valid = 1'b1; first_code = 4'd8; second_code = 4'd2;
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    chk("rst_mid.g1", 32'(grant), 32'h080);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_to = 1'b0;
    chk_idle("rst_mid");
    for (int k = 0; k < T + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid.no_g2", 32'(grant), 32'd0);
    end

    // reset wins over code_valid and done in the same cycle
    rst = 1'b1; code_valid = 1'b1; first_code = 4'd2; second_code = 4'd3; done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; code_valid = 1'b0; done = 1'b0;
    chk_idle("rst_prio");

    for (int n = 0; n < 25; n++) begin
      int f, s;
      f = $urandom_range(0, 15);
      s = ($urandom_range(0, 3) == 0) ? f : $urandom_range(0, 15);
      run_pair(f, s, $urandom_range(1, T + 2), $urandom_range(1, T + 2),
               1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
